// File: rtl/mux_tree_arbiter.sv
// Round-robin arbiter over seven requesters driving a two-stage mux tree (a..d, then e..g).
// Define MUX_TREE_ARB_TIMEOUT_EN to compile in the MAX_HOLD grant limit.
module mux_tree_arbiter #(
    parameter int MAX_HOLD = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] req,
    output logic [6:0] gnt,
    output logic       s0,
    output logic       s1,
    output logic [1:0] sel,
    output logic       valid,
    output logic [2:0] owner
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t     state;
    logic [2:0] last;
    logic [2:0] cand;
    logic       release_now;

    if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("mux_tree_arbiter: MAX_HOLD must be in 2..255");
    end

    // First set request bit searching circularly from prev+1; lowest offset wins.
    function automatic logic [2:0] next_owner(input logic [6:0] r, input logic [2:0] prev);
        logic [2:0] pick;
        logic [3:0] idx;
        pick = 3'd0;
        for (int off = 7; off >= 1; off--) begin
            idx = {1'b0, prev} + 4'(off);
            if (idx >= 4'd7) idx = idx - 4'd7;
            if (r[idx[2:0]]) pick = idx[2:0];
        end
        return pick;
    endfunction

    assign cand = next_owner(req, last);

`ifdef MUX_TREE_ARB_TIMEOUT_EN
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    logic [7:0] hold_cnt;

    always_comb begin
        release_now = !req[owner];
        if ((hold_cnt == HOLD_LAST) && ((req & ~gnt) != 7'd0)) release_now = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_cnt <= 8'd0;
        end else if (state == IDLE) begin
            hold_cnt <= 8'd0;
        end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + 8'd1;
        end
    end
`else
    always_comb begin
        release_now = !req[owner];
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            gnt   <= 7'd0;
            valid <= 1'b0;
            owner <= 3'd0;
            s0    <= 1'b0;
            s1    <= 1'b0;
            sel   <= 2'd0;
            last  <= 3'd6;
        end else begin
            case (state)
                IDLE: begin
                    if (req != 7'd0) begin
                        state <= GRANT;
                        owner <= cand;
                        gnt   <= 7'd1 << cand;
                        valid <= 1'b1;
                        if (cand < 3'd4) begin
                            {s1, s0} <= cand[1:0];
                            sel      <= 2'd0;
                        end else begin
                            {s1, s0} <= 2'd0;
                            sel      <= cand[1:0] + 2'd1;
                        end
                    end
                end
                GRANT: begin
                    // Every owner change passes through IDLE so the mux selects settle at zero.
                    if (release_now) begin
                        state <= IDLE;
                        gnt   <= 7'd0;
                        valid <= 1'b0;
                        owner <= 3'd0;
                        s0    <= 1'b0;
                        s1    <= 1'b0;
                        sel   <= 2'd0;
                        last  <= owner;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux_tree_arbiter.sv
// Randomized and directed bench for mux_tree_arbiter against a cycle-level reference model.
module tb_mux_tree_arbiter;

    localparam int MAXH = 4;

    logic       clk;
    logic       rst_n;
    logic [6:0] req;
    logic [6:0] gnt;
    logic       s0;
    logic       s1;
    logic [1:0] sel;
    logic       valid;
    logic [2:0] owner;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: owner index (-1 = nobody), previous owner, cycles granted so far.
    int m_owner;
    int m_last;
    int m_held;

    mux_tree_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (req),
        .gnt  (gnt),
        .s0   (s0),
        .s1   (s1),
        .sel  (sel),
        .valid(valid),
        .owner(owner)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_last  = 6;
        m_held  = 0;
    endtask

    task automatic model_edge(input logic [6:0] r);
        bit timeout_en;
        bit others;
        timeout_en = 1'b0;
`ifdef MUX_TREE_ARB_TIMEOUT_EN
        timeout_en = 1'b1;
`endif
        if (m_owner < 0) begin
            if (r != 7'd0) begin
                for (int off = 1; off <= 7; off++) begin
                    if (m_owner < 0 && r[(m_last + off) % 7]) m_owner = (m_last + off) % 7;
                end
                m_held = 1;
            end
        end else begin
            others = (r & ~(7'd1 << m_owner)) != 7'd0;
            if (!r[m_owner] || (timeout_en && m_held >= MAXH && others)) begin
                m_last  = m_owner;
                m_owner = -1;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [6:0] e_gnt;
        logic [1:0] e_s10;
        logic [1:0] e_sel;
        logic [2:0] e_own;
        e_gnt = 7'd0;
        e_s10 = 2'd0;
        e_sel = 2'd0;
        e_own = 3'd0;
        if (m_owner >= 0) begin
            e_gnt = 7'd1 << m_owner;
            e_own = 3'(m_owner);
            if (m_owner < 4) e_s10 = 2'(m_owner);
            else             e_sel = 2'(m_owner - 3);
        end
        chk({tag, ".gnt"},   32'(gnt),      32'(e_gnt));
        chk({tag, ".owner"}, 32'(owner),    32'(e_own));
        chk({tag, ".valid"}, 32'(valid),    32'(m_owner >= 0));
        chk({tag, ".s1s0"},  32'({s1, s0}), 32'(e_s10));
        chk({tag, ".sel"},   32'(sel),      32'(e_sel));
    endtask

    // Drive req, take one edge, advance the model and compare just after the edge.
    task automatic step(input string tag, input logic [6:0] r);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [6:0] rr;

    initial begin
        req = 7'd0;
        model_reset();
        do_reset();

        // Single requester held: grant after one edge, kept indefinitely.
        step("single", 7'b0000100);
        chk("single.owner_is_2", 32'(owner), 32'd2);
        chk("single.s1s0_is_2",  32'({s1, s0}), 32'd2);
        for (int i = 0; i < 10; i++) step("single_hold", 7'b0000100);
        step("single_drop", 7'b0000000);
        chk("single_drop.valid", 32'(valid), 32'd0);

        // Round-robin wrap and hand-off to g after owner 0 drops.
        do_reset();
        step("wrap", 7'b1000001);
        chk("wrap.owner_is_0", 32'(owner), 32'd0);
        for (int i = 0; i < 2; i++) step("wrap_hold", 7'b1000001);
        step("handoff_idle", 7'b1000000);
        step("handoff_g", 7'b1000000);
        chk("handoff.sel_is_3", 32'(sel), 32'd3);

        // Two steady requesters: timeout alternation when enabled, permanent hold otherwise.
        do_reset();
        for (int i = 0; i < 22; i++) step("steady_pair", 7'b0010010);
        step("steady_drop", 7'b0000000);
        step("steady_idle", 7'b0000000);

        // Asynchronous reset in mid-grant with owner 5, then re-grant.
        do_reset();
        step("own5", 7'b0100000);
        chk("own5.owner_is_5", 32'(owner), 32'd5);
        step("own5_hold", 7'b0100000);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_rst.gnt",   32'(gnt),   32'd0);
        chk("async_rst.valid", 32'(valid), 32'd0);
        chk("async_rst.sel",   32'(sel),   32'd0);
        chk("async_rst.s1s0",  32'({s1, s0}), 32'd0);
        #2;
        rst_n = 1'b1;
        step("regrant5", 7'b0100000);
        chk("regrant5.owner_is_5", 32'(owner), 32'd5);

        // Random request traffic with slowly flipping bits so grants persist.
        do_reset();
        rr = 7'($urandom);
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 7; b++) begin
                if ($urandom_range(0, 7) == 0) rr[b] = ~rr[b];
            end
            if ($urandom_range(0, 40) == 0) rr = 7'd0;
            step("rand", rr);
            chk("rand.onehot", 32'($countones(gnt) <= 1), 32'd1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
